// File: rtl/psram_bridge_pkg.sv
// psram_bridge_pkg: shared types and constants for the PSRAM bridge.
// Holds the CPU write FSM state enum and the legal DATA_W values.
`timescale 1ns/1ps
package psram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_ACT = 2'd1,
        ST_COMMIT = 2'd2
    } wr_state_e;

    localparam int unsigned DATA_W_BYTE = 8;
    localparam int unsigned DATA_W_WORD = 16;
    localparam int unsigned LANE_W      = 8;

    function automatic bit data_w_legal(
        input int unsigned w
    );
        return (w == DATA_W_BYTE) ||
               (w == DATA_W_WORD);
    endfunction

endpackage

// File: rtl/psram_bridge_dpram.sv
// psram_bridge_dpram: inferred true dual-port RAM, byte-write on port A,
// full-word write on port B, registered reads (1 cycle) on both ports.
// Ports:
//   clk, reset           clock, sync active-low reset (read regs only)
//   a_addr/a_we/a_be     CPU port address, write strobe, byte enables
//   a_wdata/a_rdata      CPU port write / read data
//   b_addr/b_we          fabric port address, full-word write strobe
//   b_wdata/b_rdata      fabric port write / read data
// On a same-address collision port A owns every lane it enables.
`timescale 1ns/1ps
module psram_bridge_dpram
    import psram_bridge_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic                  a_we,
    input  logic [DATA_W/8-1:0]   a_be,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic [DATA_W-1:0]     a_rdata,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic                  b_we,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic [DATA_W-1:0]     b_rdata
);

    localparam int unsigned LANES = DATA_W / LANE_W;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic              same_addr;
    logic [LANES-1:0]  a_lane_we;
    logic [LANES-1:0]  b_lane_we;

    assign same_addr = (a_addr == b_addr);

    // Fabric lanes are masked wherever the CPU writes the same word.
    always_comb begin
        a_lane_we = '0;
        b_lane_we = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            a_lane_we[i] = a_we && a_be[i];
            b_lane_we[i] = b_we &&
                           !(a_lane_we[i] && same_addr);
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (b_lane_we[i]) begin
                mem_q[b_addr][i*LANE_W +: LANE_W] <=
                    b_wdata[i*LANE_W +: LANE_W];
            end
            if (a_lane_we[i]) begin
                mem_q[a_addr][i*LANE_W +: LANE_W] <=
                    a_wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= mem_q[a_addr];
            b_rdata_q <= mem_q[b_addr];
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/psram_bridge.sv
// psram_bridge: bridges an asynchronous PSRAM-style CPU bus onto a
// dual-port RAM shared with the fabric, plus heartbeat LED.
// Ports:
//   clk, reset               clock, sync active-low reset
//   bus_ncs/nwe/nrd          CPU strobes (active-low, async)
//   bus_nbe, bus_addr        CPU byte enables (active-low), word address
//   bus_data                 CPU data (driven only during a read)
//   f_addr/f_we/f_wdata      fabric address, write, write data
//   f_rdata                  fabric read data (1-cycle latency)
//   irq, irq_ack             doorbell interrupt and its clear
//   led                      heartbeat counter bit LED_BIT
// Build option PSRAM_BRIDGE_DOORBELL_EN: a CPU write to the all-ones
// address raises irq; otherwise irq is tied low.
`timescale 1ns/1ps
module psram_bridge
    import psram_bridge_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned LED_BIT = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_ncs,
    input  logic                  bus_nwe,
    input  logic                  bus_nrd,
    input  logic [DATA_W/8-1:0]   bus_nbe,
    input  logic [ADDR_W-1:0]     bus_addr,
    inout  wire  [DATA_W-1:0]     bus_data,
    input  logic [ADDR_W-1:0]     f_addr,
    input  logic                  f_we,
    input  logic [DATA_W-1:0]     f_wdata,
    output logic [DATA_W-1:0]     f_rdata,
    output logic                  irq,
    input  logic                  irq_ack,
    output logic                  led
);

    localparam int unsigned NBE_W = DATA_W / 8;

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("psram_bridge: DATA_W must be 8 or 16");
    end

    // Strobe synchronizers; bit 1 is the synchronized value.
    logic [1:0] ncs_sync_q;
    logic [1:0] nwe_sync_q;
    logic [1:0] nrd_sync_q;
    logic       ncs_s;
    logic       nwe_s;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ncs_sync_q <= 2'b11;
            nwe_sync_q <= 2'b11;
            nrd_sync_q <= 2'b11;
        end else begin
            ncs_sync_q <= {ncs_sync_q[0], bus_ncs};
            nwe_sync_q <= {nwe_sync_q[0], bus_nwe};
            nrd_sync_q <= {nrd_sync_q[0], bus_nrd};
        end
    end

    assign ncs_s = ncs_sync_q[1];
    assign nwe_s = nwe_sync_q[1];

    // Reads are served straight from the pins, so the synchronized
    // read strobe has no consumer inside the bridge.
    logic unused_nrd_s;
    assign unused_nrd_s = nrd_sync_q[1];

    // Single-stage capture of the address/data/enable pins.
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [NBE_W-1:0]  nbe_q;

    always_ff @(posedge clk) begin
        addr_q <= bus_addr;
        data_q <= bus_data;
        nbe_q  <= bus_nbe;
    end

    // Write FSM.
    wr_state_e state_q;
    wr_state_e state_d;
    logic      wr_capture;
    logic      cpu_we;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_capture = 1'b0;
        cpu_we     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!ncs_s && !nwe_s) begin
                    state_d = ST_WR_ACT;
                end
            end
            ST_WR_ACT: begin
                wr_capture = 1'b1;
                if (ncs_s || nwe_s) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                cpu_we  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Tracks the pins through WR_ACT so COMMIT uses the final sample.
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [NBE_W-1:0]  wr_nbe_q;

    always_ff @(posedge clk) begin
        if (wr_capture) begin
            wr_addr_q <= addr_q;
            wr_data_q <= data_q;
            wr_nbe_q  <= nbe_q;
        end
    end

    // Port A serves CPU reads except in the single COMMIT cycle.
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] cpu_rdata;

    assign a_addr = cpu_we ? wr_addr_q : addr_q;

    psram_bridge_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dpram (
        .clk     (clk),
        .reset   (reset),
        .a_addr  (a_addr),
        .a_we    (cpu_we),
        .a_be    (~wr_nbe_q),
        .a_wdata (wr_data_q),
        .a_rdata (cpu_rdata),
        .b_addr  (f_addr),
        .b_we    (f_we),
        .b_wdata (f_wdata),
        .b_rdata (f_rdata)
    );

    // A cycle with both strobes low is a write, so the bridge
    // stays off the bus to avoid fighting the CPU.
    assign bus_data = (!bus_ncs && !bus_nrd && bus_nwe)
                    ? cpu_rdata
                    : {DATA_W{1'bz}};

    // Heartbeat.
    logic [LED_BIT:0] hb_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hb_q <= '0;
        end else begin
            hb_q <= hb_q + 1'b1;
        end
    end

    assign led = hb_q[LED_BIT];

`ifdef PSRAM_BRIDGE_DOORBELL_EN
    // Set has priority over a simultaneous acknowledge.
    logic irq_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else if (cpu_we && (&wr_addr_q)) begin
            irq_q <= 1'b1;
        end else if (irq_ack) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign irq = 1'b0;
`endif

endmodule
